// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5-8 data bits, none/odd/even parity, 1-2 stop bits, mid-bit sampling.
// Strobe one clk after the final stop-bit centre (+2 clk synchroniser). No backpressure: consumer must take each strobe.
module uart_rx_cfg #(
   parameter int P_CLK_FREQ  = 50_000_000,
   parameter int P_BAUD      = 115200,
   parameter int P_DATA_BITS = 8,
   parameter int P_PARITY    = 0,
   parameter int P_STOP_BITS = 1
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_rx,
   output logic [P_DATA_BITS-1:0] o_rx_data,
   output logic                   o_rx_valid,
   output logic                   o_parity_err,
   output logic                   o_frame_err,
   output logic                   o_busy
);

   localparam int LP_CNT  = P_CLK_FREQ / P_BAUD;
   localparam int LP_HALF = LP_CNT >> 1;
   localparam int LP_CW   = $clog2(LP_CNT);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic                   r_sync1;
   logic                   r_sync2;
   logic                   r_sync_d;
   logic [2:0]             r_state;
   logic [LP_CW-1:0]       r_cnt;
   logic [3:0]             r_bit;
   logic [P_DATA_BITS-1:0] r_shift;
   logic                   r_perr;
   logic                   r_ferr;
   logic                   w_fall;
   logic                   w_half;
   logic                   w_full;

   // Edge detect runs continuously, so a line held low after a break never arms a new frame.
   assign w_fall = r_sync_d & ~r_sync2;
   assign w_half = (r_cnt == LP_CW'(LP_HALF - 1));
   assign w_full = (r_cnt == LP_CW'(LP_CNT - 1));
   assign o_busy = (r_state != S_IDLE);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_sync_d <= 1'b1;
      end else begin
         r_sync1  <= i_rx;
         r_sync2  <= r_sync1;
         r_sync_d <= r_sync2;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_bit        <= '0;
         r_shift      <= '0;
         r_perr       <= 1'b0;
         r_ferr       <= 1'b0;
         o_rx_data    <= '0;
         o_rx_valid   <= 1'b0;
         o_parity_err <= 1'b0;
         o_frame_err  <= 1'b0;
      end else begin
         o_rx_valid <= 1'b0;
         r_cnt      <= w_full ? '0 : r_cnt + LP_CW'(1);
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (w_fall) begin
                  r_state <= S_START;
                  r_bit   <= '0;
                  r_perr  <= 1'b0;
                  r_ferr  <= 1'b0;
               end
            end
            S_START: begin
               if (w_half) begin
                  r_cnt   <= '0;
                  r_state <= r_sync2 ? S_IDLE : S_DATA;
               end
            end
            S_DATA: begin
               if (w_full) begin
                  r_shift <= {r_sync2, r_shift[P_DATA_BITS-1:1]};
                  if (r_bit == 4'(P_DATA_BITS - 1)) begin
                     r_bit   <= '0;
                     r_state <= (P_PARITY != 0) ? S_PARITY : S_STOP;
                  end else begin
                     r_bit <= r_bit + 4'd1;
                  end
               end
            end
            S_PARITY: begin
               if (w_full) begin
                  r_perr  <= ((^r_shift) ^ r_sync2) != (P_PARITY == 1);
                  r_state <= S_STOP;
               end
            end
            S_STOP: begin
               if (w_full) begin
                  // Leave at the centre of the last stop bit so a back-to-back start edge is seen.
                  if (r_bit == 4'(P_STOP_BITS - 1)) begin
                     r_state      <= S_IDLE;
                     r_bit        <= '0;
                     o_rx_valid   <= 1'b1;
                     o_rx_data    <= r_shift;
                     o_parity_err <= r_perr;
                     o_frame_err  <= r_ferr | ~r_sync2;
                  end else begin
                     r_ferr <= r_ferr | ~r_sync2;
                     r_bit  <= r_bit + 4'd1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations (8N1, 8E1, 7N2) checked against a frame-level model.
module tb_uart_rx_cfg;

   localparam int LPC = 20;

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] rx;
   logic [7:0] d0, d1;
   logic [6:0] d2;
   logic [2:0] vld, pe, fe, bsy;
   int         cyc = 0;
   int         n_chk = 0;
   int         n_fail = 0;

   int cfg_dw   [3] = '{8, 8, 7};
   int cfg_par  [3] = '{0, 2, 0};
   int cfg_stop [3] = '{1, 1, 2};

   exp_t q [3][$];
   exp_t hold [3];
   exp_t ce;
   logic [7:0] dd [3];
   logic [2:0] prev_vld = '0;

   uart_rx_cfg #(.P_CLK_FREQ(2_000_000), .P_BAUD(100_000)) u0 (
      .i_clk(clk), .i_rst(rst), .i_rx(rx[0]), .o_rx_data(d0), .o_rx_valid(vld[0]),
      .o_parity_err(pe[0]), .o_frame_err(fe[0]), .o_busy(bsy[0]));
   uart_rx_cfg #(.P_CLK_FREQ(2_000_000), .P_BAUD(100_000), .P_PARITY(2)) u1 (
      .i_clk(clk), .i_rst(rst), .i_rx(rx[1]), .o_rx_data(d1), .o_rx_valid(vld[1]),
      .o_parity_err(pe[1]), .o_frame_err(fe[1]), .o_busy(bsy[1]));
   uart_rx_cfg #(.P_CLK_FREQ(2_000_000), .P_BAUD(100_000), .P_DATA_BITS(7), .P_STOP_BITS(2)) u2 (
      .i_clk(clk), .i_rst(rst), .i_rx(rx[2]), .o_rx_data(d2), .o_rx_valid(vld[2]),
      .o_parity_err(pe[2]), .o_frame_err(fe[2]), .o_busy(bsy[2]));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d at cyc %0d: got %0h, expected %0h", nm, idx, cyc, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input int idx, input logic b);
      rx[idx] = b;
      tick(LPC);
   endtask

   task automatic idle(input int idx, input int nb);
      rx[idx] = 1'b1;
      tick(LPC * nb);
   endtask

   // Model: the frame's content and error flags follow directly from what is put on the line;
   // the strobe lands one clk after the last stop-bit centre, plus two synchroniser clocks.
   task automatic send_frame(input int idx, input logic [7:0] d, input bit bad_par, input bit [1:0] stop_low);
      int         dw, par, ns, nb;
      logic [7:0] dm;
      logic       pbit;
      exp_t       e;
      dw   = cfg_dw[idx];
      par  = cfg_par[idx];
      ns   = cfg_stop[idx];
      dm   = (dw == 8) ? d : (d & 8'((1 << dw) - 1));
      pbit = ((par == 1) ? ~(^dm) : (^dm)) ^ bad_par;
      nb   = dw + ((par != 0) ? 1 : 0) + ns;
      e.d   = dm;
      e.pe  = (par != 0) && bad_par;
      e.fe  = stop_low[0] | ((ns == 2) && stop_low[1]);
      e.cyc = cyc + (nb * LPC) + (LPC / 2) + 3;
      q[idx].push_back(e);
      drive_bit(idx, 1'b0);
      for (int i = 0; i < dw; i++) drive_bit(idx, dm[i]);
      if (par != 0) drive_bit(idx, pbit);
      for (int s = 0; s < ns; s++) drive_bit(idx, ~stop_low[s]);
   endtask

   task automatic rand_run(input int idx);
      logic [7:0] d;
      bit         bp;
      bit [1:0]   sl;
      int         gap;
      for (int k = 0; k < 25; k++) begin
         d   = 8'($urandom);
         bp  = ($urandom_range(3) == 0);
         sl  = ($urandom_range(3) == 0) ? 2'($urandom_range(1, (cfg_stop[idx] == 2) ? 3 : 1)) : 2'b00;
         gap = $urandom_range(0, 2);
         // A low final stop bit leaves the line low; a frame is only armed after it returns high.
         if (sl[cfg_stop[idx]-1] && gap == 0) gap = 1;
         send_frame(idx, d, bp, sl);
         if (gap > 0) idle(idx, gap);
      end
   endtask

   always @(negedge clk) begin
      dd[0] = d0;
      dd[1] = d1;
      dd[2] = {1'b0, d2};
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            chk("rst_valid", i, vld[i], 0);
            chk("rst_data", i, dd[i], 0);
            chk("rst_errs", i, {pe[i], fe[i]}, 0);
            chk("rst_busy", i, bsy[i], 0);
            hold[i] = '{d: 8'h00, pe: 1'b0, fe: 1'b0, cyc: 0};
         end else if (vld[i]) begin
            chk("strobe_width", i, prev_vld[i], 0);
            if (q[i].size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_strobe dut%0d at cyc %0d: data %0h, no frame outstanding", i, cyc, dd[i]);
            end else begin
               ce = q[i].pop_front();
               chk("data", i, dd[i], ce.d);
               chk("parity_err", i, pe[i], ce.pe);
               chk("frame_err", i, fe[i], ce.fe);
               n_chk++;
               if (cyc < ce.cyc - 2 || cyc > ce.cyc + 2) begin
                  n_fail++;
                  $display("FAIL strobe_time dut%0d: got cyc %0d, expected %0d (+/-2)", i, cyc, ce.cyc);
               end
               hold[i] = ce;
            end
         end else begin
            chk("hold_data", i, dd[i], hold[i].d);
            chk("hold_errs", i, {pe[i], fe[i]}, {hold[i].pe, hold[i].fe});
         end
         prev_vld[i] = vld[i];
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rx  = 3'b111;
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(5);

      // 8N1 0x55
      send_frame(0, 8'h55, 1'b0, 2'b00);
      idle(0, 2);
      chk("t1_data", 0, d0, 8'h55);
      chk("t1_errs", 0, {pe[0], fe[0]}, 2'b00);
      chk("t1_busy", 0, bsy[0], 0);

      // 8E1 0xA7 with the parity bit flipped to 0
      send_frame(1, 8'hA7, 1'b1, 2'b00);
      idle(1, 2);
      chk("t2_data", 1, d1, 8'hA7);
      chk("t2_perr", 1, pe[1], 1);

      // Framing error, one idle bit, then a clean frame
      send_frame(0, 8'h3C, 1'b0, 2'b01);
      idle(0, 1);
      chk("t3_data", 0, d0, 8'h3C);
      chk("t3_ferr", 0, fe[0], 1);
      send_frame(0, 8'h01, 1'b0, 2'b00);
      idle(0, 2);
      chk("t3b_data", 0, d0, 8'h01);
      chk("t3b_errs", 0, {pe[0], fe[0]}, 2'b00);

      // Short low glitch: start is rejected at the half-bit check
      rx[0] = 1'b0;
      tick(4);
      chk("t4_busy_hi", 0, bsy[0], 1);
      tick(1);
      rx[0] = 1'b1;
      tick(11);
      chk("t4_busy_lo", 0, bsy[0], 0);
      idle(0, 1);

      // Back-to-back frames with no idle gap
      send_frame(0, 8'hA5, 1'b0, 2'b00);
      send_frame(0, 8'h3C, 1'b0, 2'b00);
      idle(0, 2);
      chk("t5_data", 0, d0, 8'h3C);

      // Reset in the middle of 0xFF
      drive_bit(0, 1'b0);
      for (int i = 0; i < 4; i++) drive_bit(0, 1'b1);
      tick(5);
      rst = 1'b1;
      tick(2);
      chk("t6_busy", 0, bsy[0], 0);
      chk("t6_data", 0, d0, 8'h00);
      rst = 1'b0;
      idle(0, 2);
      send_frame(0, 8'h12, 1'b0, 2'b00);
      idle(0, 2);
      chk("t6b_data", 0, d0, 8'h12);

      // 7N2 with the second stop bit low
      send_frame(2, 8'h5A, 1'b0, 2'b10);
      idle(2, 2);
      chk("t7_data", 2, {1'b0, d2}, 8'h5A);
      chk("t7_ferr", 2, fe[2], 1);
      chk("t7_perr", 2, pe[2], 0);

      fork
         rand_run(0);
         rand_run(1);
         rand_run(2);
      join
      for (int i = 0; i < 3; i++) idle(i, 0);
      rx = 3'b111;
      tick(LPC * 3);
      for (int i = 0; i < 3; i++) begin
         chk("drain", i, q[i].size(), 0);
         chk("end_busy", i, bsy[i], 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
